// File: rtl/mac_dot_seq_if.sv
// Handshake bundle between the dot-product sequencer, its command/operand source, result sink and MAC.
// master is the sequencer side; slave is everything around it.
interface mac_dot_seq_if #(
    parameter int LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_clr;
    logic [39:0]      mac_z;
    logic             res_valid;
    logic             res_ready;
    logic [39:0]      res_data;
    logic             res_err;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, mac_z, res_ready,
        output cmd_ready, op_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_err, busy
    );

    modport slave (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, mac_z, res_ready,
        input  cmd_ready, op_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: clears the MAC, streams cmd_len operand pairs into it, returns the sum.
// Defining MAC_DOT_SEQ_TMO_EN adds a stall watchdog that aborts STREAM and flags res_err.
module mac_dot_seq #(
    parameter int LEN_W = 16
`ifdef MAC_DOT_SEQ_TMO_EN
    ,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
`endif
) (
    input logic           clk,
    input logic           reset,
    mac_dot_seq_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             cmd_ready_q;
    logic             op_ready_q;
    logic             mac_clr_q;
    logic             res_valid_q;
    logic             busy_q;
    logic [39:0]      res_data_q;
    logic             res_err_q;
    logic             accept;

`ifdef MAC_DOT_SEQ_TMO_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);
    logic [TMO_W-1:0] stall_cnt;
`endif

    assign accept = bus.op_valid && op_ready_q;

    // Operands reach the MAC only on an accepted pair, so the accumulator never drifts otherwise.
    assign bus.mac_a     = accept ? bus.op_a : 16'd0;
    assign bus.mac_b     = accept ? bus.op_b : 16'd0;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.op_ready  = op_ready_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = busy_q;

    // All handshake outputs are registered and change together with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            mac_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
`ifdef MAC_DOT_SEQ_TMO_EN
            stall_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        remaining   <= bus.cmd_len;
                        state       <= CLEAR;
                        cmd_ready_q <= 1'b0;
                        mac_clr_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        res_err_q   <= 1'b0;
`ifdef MAC_DOT_SEQ_TMO_EN
                        stall_cnt   <= '0;
`endif
                    end
                end
                CLEAR: begin
                    mac_clr_q <= 1'b0;
                    if (remaining == '0) begin
                        state       <= DONE;
                        res_data_q  <= '0;
                        res_valid_q <= 1'b1;
                    end else begin
                        state      <= STREAM;
                        op_ready_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state      <= DRAIN;
                            op_ready_q <= 1'b0;
                        end
`ifdef MAC_DOT_SEQ_TMO_EN
                        stall_cnt <= '0;
                    end else if (stall_cnt == TMO_LAST) begin
                        state      <= DRAIN;
                        op_ready_q <= 1'b0;
                        res_err_q  <= 1'b1;
                        stall_cnt  <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    // The last product entered the accumulator on the previous edge.
                    res_data_q  <= bus.mac_z;
                    res_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    op_ready_q  <= 1'b0;
                    mac_clr_q   <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: table vectors, hand-written corner sequences and random commands
// checked against a sum-of-products reference, with a behavioural 40-bit MAC attached.
module tb_mac_dot_seq;
    localparam int LEN_W = 16;
    localparam int MAXP  = 16;

    typedef struct packed {
        logic [15:0]      len;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0][3:0]  gap;
        logic [3:0]       hold;
        logic [39:0]      expData;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          compared = 0;
    int          mismatched = 0;
    int          edgeCount = 0;
    logic [39:0] macAcc;
    logic [15:0] stimA [MAXP];
    logic [15:0] stimB [MAXP];
    int          stimGap [MAXP];
    vec_t        vecs [6];

    mac_dot_seq_if #(.LEN_W(LEN_W)) bus ();

    mac_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Stand-in for the MAC datapath: registered accumulator with synchronous clear.
    always @(posedge clk or posedge reset) begin
        if (reset)            macAcc <= '0;
        else if (bus.mac_clr) macAcc <= '0;
        else                  macAcc <= macAcc + 40'(bus.mac_a) * 40'(bus.mac_b);
    end
    assign bus.mac_z = macAcc;

    task automatic checkOutput(input string label, input logic [39:0] actual, input logic [39:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", label, actual, expected);
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " cmd_ready"}, 40'(bus.cmd_ready), 40'd1);
        checkOutput({name, " op_ready"},  40'(bus.op_ready),  40'd0);
        checkOutput({name, " mac_clr"},   40'(bus.mac_clr),   40'd0);
        checkOutput({name, " res_valid"}, 40'(bus.res_valid), 40'd0);
        checkOutput({name, " res_data"},  bus.res_data,       40'd0);
        checkOutput({name, " res_err"},   40'(bus.res_err),   40'd0);
        checkOutput({name, " busy"},      40'(bus.busy),      40'd0);
        checkOutput({name, " mac_a"},     40'(bus.mac_a),     40'd0);
    endtask

    // One full command using stimA/stimB/stimGap; called and returns at a negedge in IDLE.
    task automatic applyStimulus(input string name, input int len, input int hold, input logic [39:0] expData);
        int   idx;
        int   gapLeft;
        int   budget;
        int   t0;
        int   expLat;
        logic seenOpReady;
        expLat = 1;
        if (len > 0) begin
            expLat = len + 2;
            for (int i = 0; i < len; i++) expLat += stimGap[i];
        end
        checkOutput({name, " cmd_ready idle"}, 40'(bus.cmd_ready), 40'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(len);
        t0 = edgeCount;
        @(negedge clk);
        // cmd_valid stays high with a junk length: it must be ignored outside IDLE.
        bus.cmd_len = 16'($urandom);
        checkOutput({name, " mac_clr"},       40'(bus.mac_clr),   40'd1);
        checkOutput({name, " busy"},          40'(bus.busy),      40'd1);
        checkOutput({name, " cmd_ready busy"}, 40'(bus.cmd_ready), 40'd0);

        idx = 0;
        gapLeft = (len > 0) ? stimGap[0] : 0;
        budget = 0;
        seenOpReady = 1'b0;
        while (idx < len && budget < 2000) begin
            if (bus.op_ready) begin
                seenOpReady = 1'b1;
                if (gapLeft > 0) begin
                    bus.op_valid = 1'b0;
                    bus.op_a = 16'($urandom);
                    bus.op_b = 16'($urandom);
                    #1;
                    checkOutput({name, " gap mac_a"}, 40'(bus.mac_a), 40'd0);
                    checkOutput({name, " gap mac_b"}, 40'(bus.mac_b), 40'd0);
                    gapLeft--;
                end else begin
                    bus.op_valid = 1'b1;
                    bus.op_a = stimA[idx];
                    bus.op_b = stimB[idx];
                    #1;
                    checkOutput({name, " pass mac_a"}, 40'(bus.mac_a), 40'(stimA[idx]));
                    checkOutput({name, " pass mac_b"}, 40'(bus.mac_b), 40'(stimB[idx]));
                    idx++;
                    gapLeft = (idx < len) ? stimGap[idx] : 0;
                end
            end else begin
                bus.op_valid = 1'b1;
                bus.op_a = 16'($urandom);
                bus.op_b = 16'($urandom);
                #1;
                checkOutput({name, " blocked mac_a"}, 40'(bus.mac_a), 40'd0);
            end
            @(negedge clk);
            budget++;
        end
        checkOutput({name, " pairs accepted"}, 40'(idx), 40'(len));

        budget = 0;
        while (!bus.res_valid && budget < 400) begin
            seenOpReady = seenOpReady | bus.op_ready;
            bus.op_valid = 1'b1;
            bus.op_a = 16'($urandom);
            bus.op_b = 16'($urandom);
            #1;
            checkOutput({name, " wait mac_b"}, 40'(bus.mac_b), 40'd0);
            @(negedge clk);
            budget++;
        end
        if (len == 0) checkOutput({name, " op_ready seen"}, 40'(seenOpReady), 40'd0);
        checkOutput({name, " res_valid"}, 40'(bus.res_valid), 40'd1);
        checkOutput({name, " latency"},   40'(edgeCount - (t0 + 1)), 40'(expLat));
        checkOutput({name, " res_data"},  bus.res_data, expData);
        checkOutput({name, " res_err"},   40'(bus.res_err), 40'd0);
        checkOutput({name, " mac_clr done"}, 40'(bus.mac_clr), 40'd0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput({name, " held res_valid"}, 40'(bus.res_valid), 40'd1);
            checkOutput({name, " held res_data"},  bus.res_data, expData);
            checkOutput({name, " held cmd_ready"}, 40'(bus.cmd_ready), 40'd0);
        end
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.op_valid  = 1'b0;
        checkOutput({name, " res_valid after"}, 40'(bus.res_valid), 40'd0);
        checkOutput({name, " busy after"},      40'(bus.busy),      40'd0);
    endtask

    initial begin
        int budget;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("reset");
        reset = 1'b0;
        @(negedge clk);

        // Element 0 of a/b/gap is the rightmost field.
        vecs[0] = '{len: 16'd1, a: 64'h0000_0000_0000_0003, b: 64'h0000_0000_0000_0004,
                    gap: 16'h0000, hold: 4'd0, expData: 40'd12};
        vecs[1] = '{len: 16'd3, a: 64'h0000_0001_0003_0002, b: 64'h0000_0001_0007_0005,
                    gap: 16'h0120, hold: 4'd0, expData: 40'd32};
        vecs[2] = '{len: 16'd0, a: 64'h0, b: 64'h0, gap: 16'h0000, hold: 4'd1, expData: 40'd0};
        vecs[3] = '{len: 16'd2, a: 64'h0000_0000_0014_000A, b: 64'h0000_0000_0028_001E,
                    gap: 16'h0000, hold: 4'd5, expData: 40'd1100};
        vecs[4] = '{len: 16'd2, a: 64'h0000_0000_0002_0001, b: 64'h0000_0000_0004_0003,
                    gap: 16'h0000, hold: 4'd5, expData: 40'd11};
        vecs[5] = '{len: 16'd4, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF,
                    gap: 16'h1010, hold: 4'd2, expData: 40'h03_FFF8_0004};

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                stimA[i]   = vecs[v].a[i];
                stimB[i]   = vecs[v].b[i];
                stimGap[i] = int'(vecs[v].gap[i]);
            end
            applyStimulus($sformatf("vec%0d", v), int'(vecs[v].len), int'(vecs[v].hold), vecs[v].expData);
        end

        // Reset after one of four pairs abandons the command.
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 16'd4;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset op_ready", 40'(bus.op_ready), 40'd1);
        bus.op_valid = 1'b1;
        bus.op_a     = 16'd5;
        bus.op_b     = 16'd5;
        @(negedge clk);
        bus.op_a = 16'd9;
        reset    = 1'b1;
        #1;
        checkReset("midreset");
        @(negedge clk);
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        @(negedge clk);
        stimA[0] = 16'd3;
        stimB[0] = 16'd4;
        stimGap[0] = 0;
        applyStimulus("postreset", 1, 0, 40'd12);

        // Stall after one pair of two.
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 16'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_a     = 16'd6;
        bus.op_b     = 16'd6;
        @(negedge clk);
        bus.op_valid = 1'b0;
`ifdef MAC_DOT_SEQ_TMO_EN
        budget = 0;
        while (!bus.res_valid && budget < 300) begin
            @(negedge clk);
            budget++;
            if (budget == 199) checkOutput("wdog early res_valid", 40'(bus.res_valid), 40'd0);
        end
        checkOutput("wdog res_valid", 40'(bus.res_valid), 40'd1);
        checkOutput("wdog stall window", 40'(budget >= 200 && budget <= 202), 40'd1);
        checkOutput("wdog res_err",  40'(bus.res_err), 40'd1);
        checkOutput("wdog res_data", bus.res_data, 40'd36);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checkOutput("wdog cmd_ready", 40'(bus.cmd_ready), 40'd1);
`else
        budget = 0;
        repeat (250) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("stall busy",      40'(bus.busy),      40'd1);
        checkOutput("stall op_ready",  40'(bus.op_ready),  40'd1);
        checkOutput("stall res_valid", 40'(bus.res_valid), 40'd0);
        checkOutput("stall res_err",   40'(bus.res_err),   40'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif

        // Random commands against the sum-of-products reference.
        for (int r = 0; r < 20; r++) begin
            int          len;
            logic [39:0] model;
            len   = int'($urandom_range(0, 12));
            model = '0;
            for (int i = 0; i < len; i++) begin
                stimA[i]   = 16'($urandom);
                stimB[i]   = 16'($urandom);
                stimGap[i] = int'($urandom_range(0, 2));
                model      = model + 40'(stimA[i]) * 40'(stimB[i]);
            end
            applyStimulus($sformatf("rand%0d", r), len, int'($urandom_range(0, 3)), model);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
